ysyx_220053_core_seq: RTL and testbench

//  Multi-cycle sequencer for the RV64 core: drives fetch, decode, execute (MDU), memory and

---
 rtl/ysyx_220053_pkg.sv | 8 +
 rtl/ysyx_220053_wdog.sv | 19 +
 rtl/ysyx_220053_core_seq.sv | 91 +++++++++
 tb/tb_ysyx_220053_core_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220053_pkg.sv
// ysyx_220053_pkg: sequencer state encoding and shared constants
package ysyx_220053_pkg;
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_e;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [1:0]  MULOP_NONE   = 2'b00;
endpackage

// File: rtl/ysyx_220053_wdog.sv
// ysyx_220053_wdog: clearable bus-wait counter that flags when TIMEOUT waits have elapsed
module ysyx_220053_wdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [TO_W-1:0] cnt_q;
  assign expired_o = cnt_q == TO_W'(TIMEOUT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && !expired_o) cnt_q <= cnt_q + TO_W'(1);
  end
endmodule

// File: rtl/ysyx_220053_core_seq.sv
// ysyx_220053_core_seq: multi-cycle fetch/decode/exec/mem/wb sequencer owning PC and mcycle/minstret
module ysyx_220053_core_seq
  import ysyx_220053_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  input  logic        ifu_ack,
  output logic        ir_load,
  output logic [63:0] pc,
  input  logic [63:0] dnpc,
  input  logic        dec_wen,
  input  logic        dec_memrd,
  input  logic        dec_memwr,
  input  logic [1:0]  dec_mulop,
  input  logic        dec_csrwen,
  input  logic        dec_ecall,
  input  logic        dec_ebreak,
  output logic        mdu_start,
  input  logic        mdu_done,
  output logic        lsu_req,
  input  logic        lsu_ack,
  output logic        rf_wen,
  output logic        csr_wen,
  output logic        trap_wen,
  output logic        halt,
  output logic        bus_err,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);
  state_e      state_q, state_d;
  logic [63:0] pc_q, mcycle_q, minstret_q;
  logic        to_hit, in_fetch, in_mem, commit;
  assign in_fetch = state_q == S_FETCH;
  assign in_mem   = state_q == S_MEM;
  assign commit   = state_q == S_WB;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = ifu_ack ? S_DECODE : to_hit ? S_ERR : S_FETCH;
      S_DECODE: state_d = dec_ebreak                ? S_HALT :
                          dec_mulop != MULOP_NONE   ? S_EXEC :
                          (dec_memrd || dec_memwr)  ? S_MEM  : S_WB;
      S_EXEC:   state_d = mdu_done ? S_WB : S_EXEC;
      S_MEM:    state_d = lsu_ack ? S_WB : to_hit ? S_ERR : S_MEM;
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end
  // Any state change restarts the wait count, so each bus phase gets a fresh budget.
  ysyx_220053_wdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_d != state_q),
    .en_i      ((in_fetch && !ifu_ack) || (in_mem && !lsu_ack)),
    .expired_o (to_hit)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_PC;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        pc_q       <= dnpc & ~64'd1;
        minstret_q <= minstret_q + 64'd1;
      end
      if (!halt) mcycle_q <= mcycle_q + 64'd1;
    end
  end
  // Strobes decode the state register directly so reset forces them low at once.
  assign ifu_req   = in_fetch;
  assign ir_load   = in_fetch && ifu_ack;
  assign mdu_start = (state_q == S_DECODE) && !dec_ebreak && (dec_mulop != MULOP_NONE);
  assign lsu_req   = in_mem;
  assign rf_wen    = commit && dec_wen;
  assign csr_wen   = commit && dec_csrwen;
  assign trap_wen  = commit && dec_ecall;
  assign halt      = (state_q == S_HALT) || (state_q == S_ERR);
  assign bus_err   = state_q == S_ERR;
  assign pc        = pc_q;
  assign mcycle    = mcycle_q;
  assign minstret  = minstret_q;
endmodule

// File: tb/tb_ysyx_220053_core_seq.sv
// tb_ysyx_220053_core_seq: randomized instruction streams checked against a phase-latency model
module tb_ysyx_220053_core_seq;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam int TO = 255;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ifu_req, ifu_ack = 1'b0, ir_load;
  logic [63:0] pc, dnpc = '0, mcycle, minstret;
  logic dec_wen = 0, dec_memrd = 0, dec_memwr = 0, dec_csrwen = 0, dec_ecall = 0, dec_ebreak = 0;
  logic [1:0] dec_mulop = 2'b00;
  logic mdu_start, mdu_done = 1'b0, lsu_req, lsu_ack = 1'b0;
  logic rf_wen, csr_wen, trap_wen, halt, bus_err;
  int vectors = 0, miscompares = 0;
  logic [63:0] exp_pc, exp_ret, exp_cyc;

  always #5 clk = ~clk;

  ysyx_220053_core_seq dut (
    .clk(clk), .rst_n(rst_n), .ifu_req(ifu_req), .ifu_ack(ifu_ack), .ir_load(ir_load),
    .pc(pc), .dnpc(dnpc), .dec_wen(dec_wen), .dec_memrd(dec_memrd), .dec_memwr(dec_memwr),
    .dec_mulop(dec_mulop), .dec_csrwen(dec_csrwen), .dec_ecall(dec_ecall),
    .dec_ebreak(dec_ebreak), .mdu_start(mdu_start), .mdu_done(mdu_done), .lsu_req(lsu_req),
    .lsu_ack(lsu_ack), .rf_wen(rf_wen), .csr_wen(csr_wen), .trap_wen(trap_wen),
    .halt(halt), .bus_err(bus_err), .mcycle(mcycle), .minstret(minstret)
  );

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic clear_dec;
    {dec_wen, dec_memrd, dec_memwr, dec_csrwen, dec_ecall, dec_ebreak} = '0;
    dec_mulop = 2'b00;
    {ifu_ack, lsu_ack, mdu_done} = '0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ifu_req, ir_load, mdu_start, lsu_req, rf_wen, csr_wen, trap_wen, halt, bus_err} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {ifu_req, ir_load, mdu_start, lsu_req, rf_wen, csr_wen, trap_wen, halt, bus_err});
    end
    vectors++;
    if (pc !== RST_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
    vectors++;
    if ({mcycle, minstret} !== 128'b0) begin
      miscompares++; $display("FAIL reset_counters: got mcycle=%0d minstret=%0d expected 0/0", mcycle, minstret);
    end
    clear_dec();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ifu_req !== 1'b0 || mcycle !== 64'd0) begin
      miscompares++; $display("FAIL reset_state: got ifu_req=%b mcycle=%0d expected 0/0", ifu_req, mcycle);
    end
    @(negedge clk);
    exp_pc = RST_PC; exp_ret = 0; exp_cyc = 1;
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 MDU, 4 ecall; fd = fetch wait, ed = exec/mem wait
  task automatic run_instr(input int kind, input int fd, input int ed, input logic wen,
                           input logic cwen, input logic [63:0] np);
    int total, n_req, n_ir, p_ir, n_mdu, p_mdu, n_lsu, n_rf, p_rf, n_csr, n_trap, p_trap, n_halt;
    bit memk;
    memk = (kind == 1 || kind == 2);
    total = fd + 3 + ((kind >= 1 && kind <= 3) ? ed + 1 : 0);
    {n_req, n_ir, n_mdu, n_lsu, n_rf, n_csr, n_trap, n_halt} = '0;
    {p_ir, p_mdu, p_rf, p_trap} = {-32'sd1, -32'sd1, -32'sd1, -32'sd1};
    dec_wen = wen; dec_csrwen = cwen; dec_memrd = kind == 1; dec_memwr = kind == 2;
    dec_mulop = (kind == 3) ? 2'($urandom_range(1, 3)) : 2'b00;
    dec_ecall = kind == 4; dec_ebreak = 1'b0; dnpc = np;
    vectors++;
    if (mcycle !== exp_cyc) begin miscompares++; $display("FAIL mcycle_start: got %0d expected %0d", mcycle, exp_cyc); end
    for (int c = 0; c < total; c++) begin
      ifu_ack  = (c == fd) || (c > fd && 1'($urandom));
      lsu_ack  = memk ? (c == fd + 2 + ed || (c <= fd + 1 && 1'($urandom))) : 1'($urandom);
      mdu_done = (kind == 3) ? (c == fd + 2 + ed || (c <= fd + 1 && 1'($urandom))) : 1'($urandom);
      #1;
      if (ifu_req) n_req++;
      if (ir_load) begin n_ir++; p_ir = c; end
      if (mdu_start) begin n_mdu++; p_mdu = c; end
      if (lsu_req) n_lsu++;
      if (rf_wen) begin n_rf++; p_rf = c; end
      if (csr_wen) n_csr++;
      if (trap_wen) begin n_trap++; p_trap = c; end
      if (halt || bus_err) n_halt++;
      @(negedge clk);
    end
    clear_dec();
    exp_pc = np & ~64'd1; exp_ret++; exp_cyc += 64'(total);
    vectors++;
    if (n_req !== fd + 1) begin miscompares++; $display("FAIL ifu_req_cycles k%0d: got %0d expected %0d", kind, n_req, fd + 1); end
    vectors++;
    if (n_ir !== 1 || p_ir !== fd) begin
      miscompares++; $display("FAIL ir_load k%0d: got n=%0d at %0d expected n=1 at %0d", kind, n_ir, p_ir, fd);
    end
    vectors++;
    if (n_mdu !== int'(kind == 3) || p_mdu !== ((kind == 3) ? fd + 1 : -1)) begin
      miscompares++; $display("FAIL mdu_start k%0d: got n=%0d at %0d expected n=%0d", kind, n_mdu, p_mdu, int'(kind == 3));
    end
    vectors++;
    if (n_lsu !== (memk ? ed + 1 : 0)) begin
      miscompares++; $display("FAIL lsu_req_cycles k%0d: got %0d expected %0d", kind, n_lsu, memk ? ed + 1 : 0);
    end
    vectors++;
    if (n_rf !== int'(wen) || p_rf !== (wen ? total - 1 : -1)) begin
      miscompares++; $display("FAIL rf_wen k%0d: got n=%0d at %0d expected n=%0d at %0d", kind, n_rf, p_rf, int'(wen), total - 1);
    end
    vectors++;
    if (n_csr !== int'(cwen)) begin miscompares++; $display("FAIL csr_wen k%0d: got %0d expected %0d", kind, n_csr, int'(cwen)); end
    vectors++;
    if (n_trap !== int'(kind == 4) || p_trap !== ((kind == 4) ? total - 1 : -1)) begin
      miscompares++; $display("FAIL trap_wen k%0d: got n=%0d at %0d expected n=%0d", kind, n_trap, p_trap, int'(kind == 4));
    end
    vectors++;
    if (n_halt !== 0) begin miscompares++; $display("FAIL spurious_halt k%0d: got %0d cycles expected 0", kind, n_halt); end
    vectors++;
    if (pc !== exp_pc) begin miscompares++; $display("FAIL pc k%0d: got %h expected %h", kind, pc, exp_pc); end
    vectors++;
    if (minstret !== exp_ret) begin miscompares++; $display("FAIL minstret: got %0d expected %0d", minstret, exp_ret); end
    vectors++;
    if (mcycle !== exp_cyc) begin miscompares++; $display("FAIL mcycle_end: got %0d expected %0d", mcycle, exp_cyc); end
  endtask

  task automatic test_random(input int n, input bit tight);
    int kind;
    logic w;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 4);
      w = (kind == 0) ? 1'($urandom) : (kind == 1 || kind == 3);
      run_instr(kind, tight ? 0 : $urandom_range(0, 4), tight ? 0 : $urandom_range(0, 6), w,
                (kind == 0) ? 1'($urandom) : 1'b0, {$urandom, $urandom});
    end
  endtask

  task automatic test_timeout(input bit in_mem);
    int pre, early;
    logic [63:0] frz;
    pre = in_mem ? 2 : 0; early = 0;
    dec_memrd = in_mem; dec_wen = 1'b1;
    for (int c = 0; c < pre + TO + 1; c++) begin
      ifu_ack  = in_mem && (c == 0 || 1'($urandom));
      lsu_ack  = in_mem ? (c < 2 && 1'($urandom)) : 1'($urandom);
      mdu_done = 1'($urandom);
      #1;
      if (halt) early++;
      @(negedge clk);
    end
    clear_dec();
    frz = exp_cyc + 64'(pre + TO + 1);
    #1;
    vectors++;
    if (early !== 0) begin miscompares++; $display("FAIL timeout_early m%0d: got %0d halted cycles expected 0", in_mem, early); end
    vectors++;
    if ({halt, bus_err, ifu_req, lsu_req} !== 4'b1100) begin
      miscompares++; $display("FAIL timeout_err m%0d: got %b expected 1100", in_mem, {halt, bus_err, ifu_req, lsu_req});
    end
    repeat (3) begin
      {ifu_ack, lsu_ack, mdu_done} = 3'($urandom);
      @(negedge clk);
    end
    clear_dec();
    #1;
    vectors++;
    if (mcycle !== frz || {halt, bus_err} !== 2'b11) begin
      miscompares++; $display("FAIL err_frozen m%0d: got mcycle=%0d hb=%b expected %0d/11", in_mem, mcycle, {halt, bus_err}, frz);
    end
  endtask

  task automatic test_ebreak;
    int fd, n_bad;
    logic [63:0] frz;
    fd = $urandom_range(0, 3); n_bad = 0;
    dec_ebreak = 1'b1; dec_wen = 1'b1; dec_csrwen = 1'b1; dec_mulop = 2'b01; dec_memrd = 1'b1;
    dec_ecall = 1'b1; dnpc = {$urandom, $urandom};
    for (int c = 0; c < fd + 2; c++) begin
      ifu_ack = (c == fd); lsu_ack = 1'($urandom); mdu_done = 1'($urandom);
      #1;
      if (mdu_start || rf_wen || csr_wen || trap_wen || lsu_req) n_bad++;
      @(negedge clk);
    end
    frz = exp_cyc + 64'(fd + 2);
    #1;
    vectors++;
    if ({halt, bus_err} !== 2'b10 || mcycle !== frz) begin
      miscompares++; $display("FAIL ebreak_halt: got hb=%b mcycle=%0d expected 10/%0d", {halt, bus_err}, mcycle, frz);
    end
    repeat (5) begin
      @(negedge clk);
      {ifu_ack, lsu_ack, mdu_done} = 3'($urandom);
      #1;
      if (ifu_req || ir_load || mdu_start || rf_wen || csr_wen || trap_wen || lsu_req) n_bad++;
    end
    vectors++;
    if (n_bad !== 0) begin miscompares++; $display("FAIL ebreak_strobes: got %0d strobe cycles expected 0", n_bad); end
    vectors++;
    if (mcycle !== frz || minstret !== exp_ret || pc !== exp_pc || halt !== 1'b1) begin
      miscompares++; $display("FAIL ebreak_frozen: got mcycle=%0d minstret=%0d pc=%h expected %0d/%0d/%h",
                              mcycle, minstret, pc, frz, exp_ret, exp_pc);
    end
    clear_dec();
  endtask

  task automatic test_reset_mid_mem;
    dec_memrd = 1'b1; dec_wen = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ifu_ack = (c == 0); lsu_ack = 1'b0;
      #1;
      if (c == 3) begin
        vectors++;
        if (lsu_req !== 1'b1) begin miscompares++; $display("FAIL mid_mem_req: got %b expected 1", lsu_req); end
      end
      if (c < 3) @(negedge clk);
    end
    test_reset();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    run_instr(0, 0, 0, 1'b1, 1'b0, RST_PC + 64'd4);
    run_instr(1, $urandom_range(0, 2), 3, 1'b1, 1'b0, exp_pc + 64'd4);
    run_instr(3, 0, 4, 1'b1, 1'b0, exp_pc + 64'd4);
    run_instr(4, 0, 0, 1'b0, 1'b0, 64'h8000_1000);
    run_instr(2, 1, 0, 1'b0, 1'b0, 64'h8000_1005);
    test_random(40, 1'b0);
    test_random(15, 1'b1);
    run_instr(0, TO, 0, 1'b1, 1'b1, exp_pc + 64'd4);
    test_timeout(1'b0);
    test_reset();
    test_random(5, 1'b0);
    test_timeout(1'b1);
    test_reset();
    test_random(5, 1'b0);
    test_reset_mid_mem();
    test_random(5, 1'b0);
    test_ebreak();
    test_reset();
    test_random(3, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
